// File: rtl/register_serial_reader_if.sv
// Bus bundle for the serial register reader: load handshake, parallel word,
// and the serial line with its status flags.
interface register_serial_reader_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] register_input;
  logic             serial_out;
  logic             busy;
  logic             ready;
  logic             done;

  modport master (
    output load,
    output register_input,
    input  serial_out,
    input  busy,
    input  ready,
    input  done
  );

  modport slave (
    input  load,
    input  register_input,
    output serial_out,
    output busy,
    output ready,
    output done
  );
endinterface

// File: rtl/register_serial_reader.sv
// Captures a parallel word on load and shifts it out one bit per clock,
// optionally followed by an even-parity bit; all outputs come from flops.
module register_serial_reader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input logic                     clock,
  input logic                     clear_n,
  register_serial_reader_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_count;
  logic             parity_bit;
  logic             serial_q;
  logic             busy_q;
  logic             ready_q;
  logic             done_q;

  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  // The bit currently on the line always sits at the outgoing end of shift_reg,
  // so the bit for the following cycle is its neighbour.
  always_comb begin
    first_bit = MSB_FIRST ? bus.register_input[WIDTH-1] : bus.register_input[0];
    next_bit  = MSB_FIRST ? shift_reg[WIDTH-2] : shift_reg[1];
    shifted   = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                          : {1'b0, shift_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_count  <= '0;
      parity_bit <= 1'b0;
      serial_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            state      <= SHIFT;
            shift_reg  <= bus.register_input;
            parity_bit <= ^bus.register_input;
            bit_count  <= '0;
            serial_q   <= first_bit;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
          end
        end
        SHIFT: begin
          shift_reg <= shifted;
          bit_count <= bit_count + CW'(1);
          if (bit_count == LAST_BIT) begin
            if (PARITY_EN) begin
              state    <= PARITY;
              serial_q <= parity_bit;
            end else begin
              state    <= DONE;
              serial_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end else begin
            serial_q <= next_bit;
          end
        end
        PARITY: begin
          state    <= DONE;
          serial_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.busy       = busy_q;
  assign bus.ready      = ready_q;
  assign bus.done       = done_q;

  // The status flags are mutually exclusive and done never lasts two cycles.
  a_busy_ready_exclusive : assert property (
    @(posedge clock) disable iff (!clear_n) !(busy_q && ready_q));
  a_done_single_pulse : assert property (
    @(posedge clock) disable iff (!clear_n) done_q |=> !done_q);
endmodule

// File: tb/tb_register_serial_reader.sv
// Bench for register_serial_reader: three configurations (MSB, MSB+parity, LSB)
// checked every cycle against a frame-list model plus literal frame expectations.
module tb_register_serial_reader;
  localparam int WIDTH = 8;
  localparam int N_DUT = 3;
  localparam logic [3:0] IDLE_OUT = 4'b0010;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       load_v [N_DUT];
  logic [7:0] data_v [N_DUT];
  logic [3:0] obs    [N_DUT];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit checking = 1'b0;

  logic [3:0]  exp_q [N_DUT][$];
  bit          cur_idle [N_DUT];
  logic [15:0] rec_buf [N_DUT];
  logic [15:0] last_frame [N_DUT];
  int          rec_nb [N_DUT];
  int          last_nbits [N_DUT];
  int          frame_count [N_DUT];
  int          last_done [N_DUT];
  int          last_gap [N_DUT];

  always #5 clock = ~clock;

  register_serial_reader_if #(.WIDTH(WIDTH)) bus_msb ();
  register_serial_reader_if #(.WIDTH(WIDTH)) bus_par ();
  register_serial_reader_if #(.WIDTH(WIDTH)) bus_lsb ();

  assign bus_msb.load = load_v[0];
  assign bus_msb.register_input = data_v[0];
  assign bus_par.load = load_v[1];
  assign bus_par.register_input = data_v[1];
  assign bus_lsb.load = load_v[2];
  assign bus_lsb.register_input = data_v[2];

  assign obs[0] = {bus_msb.serial_out, bus_msb.busy, bus_msb.ready, bus_msb.done};
  assign obs[1] = {bus_par.serial_out, bus_par.busy, bus_par.ready, bus_par.done};
  assign obs[2] = {bus_lsb.serial_out, bus_lsb.busy, bus_lsb.ready, bus_lsb.done};

  register_serial_reader #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_msb (
    .clock(clock), .clear_n(clear_n), .bus(bus_msb));
  register_serial_reader #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_par (
    .clock(clock), .clear_n(clear_n), .bus(bus_par));
  register_serial_reader #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_lsb (
    .clock(clock), .clear_n(clear_n), .bus(bus_lsb));

  function automatic bit msb_cfg(input int d);
    return d != 2;
  endfunction

  function automatic bit par_cfg(input int d);
    return d == 1;
  endfunction

  // One frame is a list of output cycles {serial, busy, ready, done}:
  // the data bits, an optional parity bit, then the done cycle.
  function automatic logic [3:0] frame_entry(input logic [7:0] value, input bit msb,
                                             input bit par, input int idx);
    logic b;
    if (idx < WIDTH) begin
      b = msb ? value[WIDTH-1-idx] : value[idx];
      return {b, 3'b100};
    end
    if (par && idx == WIDTH) return {^value, 3'b100};
    return 4'b0001;
  endfunction

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int d, input logic ld, input logic [7:0] val);
    load_v[d] = ld;
    data_v[d] = val;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Model: a load seen at the end of an idle cycle queues a whole frame.
  always @(posedge clock) begin
    cyc++;
    for (int d = 0; d < N_DUT; d++) begin
      if (clear_n !== 1'b1) begin
        exp_q[d].delete();
      end else if (cur_idle[d] && load_v[d] === 1'b1) begin
        for (int i = 0; i < WIDTH + 1 + int'(par_cfg(d)); i++)
          exp_q[d].push_back(frame_entry(data_v[d], msb_cfg(d), par_cfg(d), i));
      end
    end
  end

  always @(negedge clock) begin
    for (int d = 0; d < N_DUT; d++) begin
      logic [3:0] e;
      if (exp_q[d].size() > 0) begin
        e = exp_q[d].pop_front();
        cur_idle[d] = 1'b0;
      end else begin
        e = IDLE_OUT;
        cur_idle[d] = 1'b1;
      end
      if (checking)
        check_output($sformatf("dut%0d_cycle%0d", d, cyc), {12'd0, obs[d]}, {12'd0, e});

      if (obs[d][1] === 1'b1) begin
        rec_buf[d] = '0;
        rec_nb[d]  = 0;
      end else if (obs[d][2] === 1'b1) begin
        rec_buf[d] = {rec_buf[d][14:0], obs[d][3]};
        rec_nb[d]++;
      end else if (obs[d][0] === 1'b1) begin
        last_frame[d]  = rec_buf[d];
        last_nbits[d]  = rec_nb[d];
        frame_count[d]++;
        last_gap[d]    = cyc - last_done[d];
        last_done[d]   = cyc;
        rec_buf[d]     = '0;
        rec_nb[d]      = 0;
      end
    end
  end

  initial begin
    for (int d = 0; d < N_DUT; d++) begin
      cur_idle[d] = 1'b0;
      rec_buf[d] = '0;
      last_frame[d] = '0;
      rec_nb[d] = 0;
      last_nbits[d] = 0;
      frame_count[d] = 0;
      last_done[d] = 0;
      last_gap[d] = 0;
      apply_stimulus(d, 1'b1, 8'hFF);
    end
    clear_n = 1'b0;

    // Reset held two cycles with load asserted.
    wait_cycles(2);
    for (int d = 0; d < N_DUT; d++)
      check_output($sformatf("reset_dut%0d", d), {12'd0, obs[d]}, {12'd0, IDLE_OUT});
    checking = 1'b1;
    for (int d = 0; d < N_DUT; d++) apply_stimulus(d, 1'b0, 8'h00);
    clear_n = 1'b1;

    // Basic MSB-first frame of 10.
    wait_cycles(1);
    apply_stimulus(0, 1'b1, 8'd10);
    wait_cycles(1);
    apply_stimulus(0, 1'b0, 8'd0);
    wait_cycles(12);
    check_output("basic_bits", last_frame[0], 16'h000A);
    check_output("basic_nbits", 16'(last_nbits[0]), 16'd8);
    check_output("basic_frames", 16'(frame_count[0]), 16'd1);

    // Load during the third data cycle is ignored.
    apply_stimulus(0, 1'b1, 8'd15);
    wait_cycles(1);
    apply_stimulus(0, 1'b0, 8'd0);
    wait_cycles(2);
    apply_stimulus(0, 1'b1, 8'd3);
    wait_cycles(1);
    apply_stimulus(0, 1'b0, 8'd0);
    wait_cycles(14);
    check_output("ignored_bits", last_frame[0], 16'h000F);
    check_output("ignored_frames", 16'(frame_count[0]), 16'd2);

    // Reset after four bits of A5 aborts the frame without a done pulse.
    apply_stimulus(0, 1'b1, 8'hA5);
    wait_cycles(1);
    apply_stimulus(0, 1'b0, 8'd0);
    wait_cycles(3);
    clear_n = 1'b0;
    wait_cycles(1);
    check_output("abort_idle", {12'd0, obs[0]}, {12'd0, IDLE_OUT});
    clear_n = 1'b1;
    wait_cycles(12);
    check_output("abort_no_done", 16'(frame_count[0]), 16'd2);
    apply_stimulus(0, 1'b1, 8'd5);
    wait_cycles(1);
    apply_stimulus(0, 1'b0, 8'd0);
    wait_cycles(12);
    check_output("after_abort_bits", last_frame[0], 16'h0005);
    check_output("after_abort_frames", 16'(frame_count[0]), 16'd3);

    // Parity appended after the data bits.
    apply_stimulus(1, 1'b1, 8'd7);
    wait_cycles(1);
    apply_stimulus(1, 1'b0, 8'd0);
    wait_cycles(13);
    check_output("parity7_bits", last_frame[1], 16'h000F);
    check_output("parity7_nbits", 16'(last_nbits[1]), 16'd9);
    check_output("parity7_bit", {15'd0, last_frame[1][0]}, 16'd1);
    apply_stimulus(1, 1'b1, 8'd3);
    wait_cycles(1);
    apply_stimulus(1, 1'b0, 8'd0);
    wait_cycles(13);
    check_output("parity3_bits", last_frame[1], 16'h0006);
    check_output("parity3_bit", {15'd0, last_frame[1][0]}, 16'd0);

    // LSB-first back-to-back frames with load held high: three frames.
    apply_stimulus(2, 1'b1, 8'd10);
    wait_cycles(21);
    apply_stimulus(2, 1'b0, 8'd0);
    wait_cycles(12);
    check_output("lsb_bits", last_frame[2], 16'h0050);
    check_output("lsb_frames", 16'(frame_count[2]), 16'd3);
    check_output("lsb_period", 16'(last_gap[2]), 16'd10);

    wait_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
